// File: rtl/ahb_arbiter_pkg.sv
// ============================================================================
// Module   : ahb_arbiter_pkg
// Purpose  : Shared AHB transfer/burst encodings and arbiter state type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_t;

    localparam int c_cnt_w = 5;

    // Zero marks an undefined-length burst (SINGLE/INCR) that may be broken.
    function automatic logic [c_cnt_w-1:0] burst_len(input hburst_t burst);
        logic [c_cnt_w-1:0] len;
        case (burst)
            HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd0;
        endcase
        return len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_arb_pick.sv
// ============================================================================
// Module   : ahb_arb_pick
// Purpose  : Combinational highest-priority selector with round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arb_pick
    import ahb_arbiter_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int PRIOR_W  = 1,
    parameter int MASTER_W = 2
) (
    input  logic [N_MASTER-1:0]         req,
    input  logic [N_MASTER*PRIOR_W-1:0] prior,
    input  logic [MASTER_W-1:0]         rr_ptr,
    output logic [N_MASTER-1:0]         winner,
    output logic                        tie
);

    logic [PRIOR_W-1:0] w_max;

    always_comb begin
        w_max = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (req[i] && (prior[i*PRIOR_W +: PRIOR_W] > w_max)) begin
                w_max = prior[i*PRIOR_W +: PRIOR_W];
            end
        end
    end

    // Distance 0 is the master just after rr_ptr; the pointer itself is last.
    always_comb begin
        int w_d;
        int w_best_d;
        int w_n_cand;
        winner   = '0;
        tie      = 1'b0;
        w_d      = 0;
        w_best_d = N_MASTER;
        w_n_cand = 0;
        for (int i = 0; i < N_MASTER; i++) begin
            w_d = (i + N_MASTER - 1 - int'(rr_ptr)) % N_MASTER;
            if (req[i] && (prior[i*PRIOR_W +: PRIOR_W] == w_max)) begin
                w_n_cand = w_n_cand + 1;
                if (w_d < w_best_d) begin
                    w_best_d  = w_d;
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end
        tie = (w_n_cand > 1);
    end

endmodule

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
// Module   : ahb_arbiter
// Purpose  : AHB bus arbiter, priority + round-robin, burst-aware grant.
//            Optional master locking enabled by defining AHB_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arbiter
    import ahb_arbiter_pkg::*;
#(
    parameter int N_MASTER       = 4,
    parameter int N_PRIOR        = 2,
    parameter int DEFAULT_MASTER = 0,
    localparam int PRIOR_W  = (N_PRIOR  > 1) ? $clog2(N_PRIOR)  : 1,
    localparam int MASTER_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                        hclk,
    input  logic                        hreset_n,
    input  logic [N_MASTER-1:0]         hbusreq,
    input  logic [N_MASTER*PRIOR_W-1:0] hprior,
    input  logic [1:0]                  htrans,
    input  logic [2:0]                  hburst,
    input  logic                        hready,
`ifdef AHB_ARB_LOCK_EN
    input  logic [N_MASTER-1:0]         hlock,
`endif
    output logic [N_MASTER-1:0]         hgrant,
    output logic [MASTER_W-1:0]         hmaster,
    output logic [MASTER_W-1:0]         hmaster_data,
    output logic                        arb_busy
);

    localparam logic [N_MASTER-1:0] c_default_grant = N_MASTER'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_W-1:0] c_default_idx   = MASTER_W'(DEFAULT_MASTER);

    function automatic logic [MASTER_W-1:0] f_onehot_idx(input logic [N_MASTER-1:0] oh);
        logic [MASTER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (oh[i]) idx = MASTER_W'(i);
        end
        return idx;
    endfunction

    arb_state_t            r_state, w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic [N_MASTER-1:0]   r_grant, w_grant_nxt;
    logic [MASTER_W-1:0]   r_hmaster, w_hmaster_nxt;
    logic [MASTER_W-1:0]   r_hmaster_data;
    logic [MASTER_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic                  r_lock, w_lock_nxt;

    htrans_t               w_htrans;
    logic [c_cnt_w-1:0]    w_len;
    logic                  w_fixed;
    logic                  w_arb_pt;
    logic                  w_release_idle;
    logic                  w_lock_req;
    logic [N_MASTER-1:0]   w_pick;
    logic                  w_tie;

    assign w_htrans = htrans_t'(htrans);
    assign w_len    = burst_len(hburst_t'(hburst));
    assign w_fixed  = (w_len != '0);

`ifdef AHB_ARB_LOCK_EN
    assign w_lock_req = |(hlock & r_grant);
`else
    assign w_lock_req = 1'b0;
`endif

    ahb_arb_pick #(
        .N_MASTER (N_MASTER),
        .PRIOR_W  (PRIOR_W),
        .MASTER_W (MASTER_W)
    ) u_pick (
        .req    (hbusreq),
        .prior  (hprior),
        .rr_ptr (r_rr_ptr),
        .winner (w_pick),
        .tie    (w_tie)
    );

    // Burst tracking: decide whether this hready cycle is an arbitration point.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_arb_pt       = 1'b0;
        w_release_idle = 1'b0;
        if (hready) begin
            case (r_state)
                ARB_BURST: begin
                    case (w_htrans)
                        HTRANS_IDLE: begin
                            w_arb_pt       = 1'b1;
                            w_release_idle = 1'b1;
                        end
                        HTRANS_SEQ: begin
                            if (r_cnt == 5'd1) w_arb_pt = 1'b1;
                            else               w_cnt_nxt = r_cnt - 5'd1;
                        end
                        HTRANS_NONSEQ: begin
                            if (w_fixed) w_cnt_nxt = w_len - 5'd1;
                            else         w_arb_pt  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if ((w_htrans == HTRANS_NONSEQ) && w_fixed) begin
                        w_state_nxt = ARB_BURST;
                        w_cnt_nxt   = w_len - 5'd1;
                    end else begin
                        w_arb_pt = 1'b1;
                    end
                end
            endcase
            if (w_arb_pt) begin
                w_cnt_nxt   = '0;
                w_state_nxt = (w_release_idle || !(|hbusreq)) ? ARB_IDLE : ARB_OWN;
            end
        end
    end

    // A lock is honoured for one extra point after hlock falls so the
    // final locked transfer still completes under the same owner.
    always_comb begin
        w_grant_nxt   = r_grant;
        w_hmaster_nxt = r_hmaster;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_lock_nxt    = r_lock;
        if (w_arb_pt) begin
            w_lock_nxt = w_lock_req;
            if (w_lock_req || r_lock) begin
                w_grant_nxt = r_grant;
            end else if (|hbusreq) begin
                w_grant_nxt   = w_pick;
                w_hmaster_nxt = f_onehot_idx(w_pick);
                if (w_tie) w_rr_ptr_nxt = f_onehot_idx(w_pick);
            end else begin
                w_grant_nxt   = c_default_grant;
                w_hmaster_nxt = c_default_idx;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state        <= ARB_IDLE;
            r_cnt          <= '0;
            r_grant        <= c_default_grant;
            r_hmaster      <= c_default_idx;
            r_hmaster_data <= c_default_idx;
            r_rr_ptr       <= c_default_idx;
            r_lock         <= 1'b0;
        end else if (hready) begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_grant        <= w_grant_nxt;
            r_hmaster      <= w_hmaster_nxt;
            r_hmaster_data <= r_hmaster;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_lock         <= w_lock_nxt;
        end
    end

    assign hgrant       = r_grant;
    assign hmaster      = r_hmaster;
    assign hmaster_data = r_hmaster_data;
    assign arb_busy     = (r_state == ARB_BURST);

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================================
// Module   : tb_ahb_arbiter
// Purpose  : Directed self-checking bench for ahb_arbiter (AHB_ARB_LOCK_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_arbiter;

    logic       hclk;
    logic       hreset_n;
    logic [3:0] hbusreq;
    logic [3:0] hprior;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
`ifdef AHB_ARB_LOCK_EN
    logic [3:0] hlock;
`endif
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       arb_busy;

    int n_vec;
    int n_err;

    ahb_arbiter #(
        .N_MASTER       (4),
        .N_PRIOR        (2),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk         (hclk),
        .hreset_n     (hreset_n),
        .hbusreq      (hbusreq),
        .hprior       (hprior),
        .htrans       (htrans),
        .hburst       (hburst),
        .hready       (hready),
`ifdef AHB_ARB_LOCK_EN
        .hlock        (hlock),
`endif
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .arb_busy     (arb_busy)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic cyc;
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset;
        hreset_n = 1'b0;
        hbusreq  = 4'b0000;
        hprior   = 4'b0000;
        htrans   = 2'd0;
        hburst   = 3'd0;
        hready   = 1'b1;
`ifdef AHB_ARB_LOCK_EN
        hlock    = 4'b0000;
`endif
        cyc();
        cyc();
        n_vec++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmaster_data !== 2'd0 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got grant=%b m=%0d md=%0d busy=%b, expected 0001/0/0/0",
                     hgrant, hmaster, hmaster_data, arb_busy);
        end
        #2 hreset_n = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmaster_data !== 2'd0 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got grant=%b m=%0d md=%0d busy=%b, expected 0001/0/0/0",
                     hgrant, hmaster, hmaster_data, arb_busy);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [4] = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
        logic [1:0] exp_m [4] = '{2'd2, 2'd1, 2'd2, 2'd1};
        logic [1:0] exp_d [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        // Tie between 0 and 1 from pointer 0 selects 1 and moves the pointer.
        hbusreq = 4'b0011;
        htrans  = 2'd2;
        hburst  = 3'd0;
        cyc();
        n_vec++;
        if (hgrant !== 4'b0010 || hmaster_data !== 2'd0) begin
            n_err++;
            $display("FAIL rr_prime: got grant=%b md=%0d, expected 0010/0", hgrant, hmaster_data);
        end
        hbusreq = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (hgrant !== exp_g[i] || hmaster !== exp_m[i] || hmaster_data !== exp_d[i]) begin
                n_err++;
                $display("FAIL rr_step%0d: got grant=%b m=%0d md=%0d, expected %b/%0d/%0d",
                         i, hgrant, hmaster, hmaster_data, exp_g[i], exp_m[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_priority;
        hbusreq = 4'b1110;
        hprior  = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++;
            if (hgrant !== 4'b1000 || hmaster !== 2'd3) begin
                n_err++;
                $display("FAIL prio_hold%0d: got grant=%b m=%0d, expected 1000/3", i, hgrant, hmaster);
            end
        end
    endtask

    task automatic test_fixed_burst;
        logic [3:0] exp_g [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        logic [1:0] tr    [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        logic       rdy   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        hbusreq = 4'b0010;
        hprior  = 4'b0000;
        htrans  = 2'd2;
        hburst  = 3'd0;
        cyc();
        n_vec++;
        if (hgrant !== 4'b0010) begin
            n_err++;
            $display("FAIL burst_setup: got grant=%b, expected 0010", hgrant);
        end
        // INCR4 by master 1 while master 2 waits at higher priority,
        // with two wait states inside the burst.
        hbusreq = 4'b0110;
        hprior  = 4'b0100;
        hburst  = 3'd3;
        for (int i = 0; i < 5; i++) begin
            htrans = tr[i];
            hready = rdy[i];
            cyc();
            n_vec++;
            if (hgrant !== exp_g[i] || arb_busy !== 1'b1) begin
                n_err++;
                $display("FAIL burst_beat%0d: got grant=%b busy=%b, expected %b/1",
                         i, hgrant, arb_busy, exp_g[i]);
            end
        end
        htrans = 2'd3;
        hready = 1'b1;
        cyc();
        n_vec++;
        if (hgrant !== 4'b0100 || hmaster !== 2'd2 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_end: got grant=%b m=%0d busy=%b, expected 0100/2/0",
                     hgrant, hmaster, arb_busy);
        end
    endtask

    task automatic test_early_term;
        hbusreq = 4'b0010;
        hprior  = 4'b0000;
        htrans  = 2'd2;
        hburst  = 3'd0;
        cyc();
        hbusreq = 4'b0110;
        hprior  = 4'b0100;
        hburst  = 3'd4;
        for (int i = 0; i < 3; i++) begin
            htrans = (i == 0) ? 2'd2 : 2'd3;
            cyc();
            n_vec++;
            if (hgrant !== 4'b0010 || arb_busy !== 1'b1) begin
                n_err++;
                $display("FAIL wrap8_beat%0d: got grant=%b busy=%b, expected 0010/1", i, hgrant, arb_busy);
            end
        end
        htrans = 2'd0;
        cyc();
        n_vec++;
        if (hgrant !== 4'b0100 || hmaster !== 2'd2 || hmaster_data !== 2'd1 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wrap8_idle: got grant=%b m=%0d md=%0d busy=%b, expected 0100/2/1/0",
                     hgrant, hmaster, hmaster_data, arb_busy);
        end
    endtask

    task automatic test_wait_states;
        hbusreq = 4'b0000;
        hready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_vec++;
            if (hgrant !== 4'b0100 || hmaster !== 2'd2 || hmaster_data !== 2'd1) begin
                n_err++;
                $display("FAIL wait%0d: got grant=%b m=%0d md=%0d, expected 0100/2/1",
                         i, hgrant, hmaster, hmaster_data);
            end
        end
        hready  = 1'b1;
        hbusreq = 4'b0100;
        cyc();
        n_vec++;
        if (hgrant !== 4'b0100 || hmaster_data !== 2'd2) begin
            n_err++;
            $display("FAIL wait_release: got grant=%b md=%0d, expected 0100/2", hgrant, hmaster_data);
        end
        hbusreq = 4'b0000;
        cyc();
        n_vec++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL park_default: got grant=%b m=%0d busy=%b, expected 0001/0/0",
                     hgrant, hmaster, arb_busy);
        end
    endtask

    task automatic test_reset_mid_burst;
        hbusreq = 4'b1000;
        hprior  = 4'b0000;
        htrans  = 2'd2;
        hburst  = 3'd0;
        cyc();
        hburst = 3'd7;
        cyc();
        htrans = 2'd3;
        cyc();
        cyc();
        n_vec++;
        if (hgrant !== 4'b1000 || arb_busy !== 1'b1) begin
            n_err++;
            $display("FAIL incr16_run: got grant=%b busy=%b, expected 1000/1", hgrant, arb_busy);
        end
        #2 hreset_n = 1'b0;
        #1;
        n_vec++;
        if (hgrant !== 4'b0001 || hmaster !== 2'd0 || hmaster_data !== 2'd0 || arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got grant=%b m=%0d md=%0d busy=%b, expected 0001/0/0/0",
                     hgrant, hmaster, hmaster_data, arb_busy);
        end
        hbusreq = 4'b0000;
        htrans  = 2'd0;
        hburst  = 3'd0;
        cyc();
        hreset_n = 1'b1;
        cyc();
    endtask

`ifdef AHB_ARB_LOCK_EN
    task automatic test_lock;
        logic [3:0] exp_g [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
        logic [3:0] lk    [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        hbusreq = 4'b0100;
        htrans  = 2'd2;
        cyc();
        hbusreq = 4'b1100;
        hprior  = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            hlock = lk[i];
            cyc();
            n_vec++;
            if (hgrant !== exp_g[i]) begin
                n_err++;
                $display("FAIL lock_step%0d: got grant=%b, expected %b", i, hgrant, exp_g[i]);
            end
        end
        hlock = 4'b0000;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_round_robin();
        test_priority();
        test_fixed_burst();
        test_early_term();
        test_wait_states();
        test_reset_mid_burst();
`ifdef AHB_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Shares the AHB_bus address/data phases between N_MASTER masters.
- Each master presents a request and a programmable priority.
- The arbiter issues a registered one-hot grant and the address- and data-phase owner indices used by the bus master-side mux.
- Fixed-length bursts are never broken; arbitration happens only at legal transfer boundaries.

Parameters:
- N_MASTER, 4, number of requesting masters.
- N_PRIOR, 2, number of priority levels; PRIOR_W = $clog2(N_PRIOR).
- DEFAULT_MASTER, 0, master parked on the bus when nobody requests.

Ports:
- hclk  in  1  bus clock
- hreset_n  in  1  asynchronous active-low reset
- hbusreq  in  N_MASTER  per-master bus request
- hprior  in  N_MASTER x PRIOR_W  per-master priority; higher value wins
- htrans  in  2  htrans of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hburst  in  3  hburst of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- hready  in  1  hready from the selected slave
- hgrant  out  N_MASTER  registered one-hot grant
- hmaster  out  $clog2(N_MASTER)  address-phase owner index
- hmaster_data  out  $clog2(N_MASTER)  data-phase owner index
- arb_busy  out  1  high while a fixed-length burst is in progress

Behaviour:
Reset:
- hgrant = one-hot(DEFAULT_MASTER); hmaster = hmaster_data = DEFAULT_MASTER.
- arb_busy = 0; state = ARB_IDLE; beat counter = 0; round-robin pointer = DEFAULT_MASTER.
- Reset asserted mid-burst forces these values immediately, asynchronously.

Transfer accept and beat counter:
- A transfer is accepted when hready=1 and htrans is NONSEQ or SEQ.
- NONSEQ accepted with a fixed burst (hburst >= 2): cnt <= len-1, where len is 4, 8 or 16; state -> ARB_BURST.
- SEQ accepted in ARB_BURST: cnt decrements.

States:
- ARB_IDLE: owner is the parked/default master or has released. Arbitration point whenever hready=1.
- ARB_OWN: owner is doing SINGLE or INCR (undefined-length) transfers. Arbitration point on any hready=1 cycle.
- ARB_BURST: fixed burst in progress. Arbitration point only on one of these hready=1 cycles:
  - SEQ accepted with cnt==1 (last beat); or
  - htrans=IDLE (early termination) -> ARB_IDLE.
- BUSY beats hold the state and leave cnt unchanged.

Arbitration point:
- Winner is the requesting master with the highest hprior.
- Ties are broken round-robin, starting from the index after the last granted master.
- No requests: grant DEFAULT_MASTER.
- hgrant/hmaster update on the next hclk edge; one-cycle grant latency.
- The round-robin pointer updates only when the new winner came from a tie.
- The owner keeps the bus if it still requests and nobody strictly higher, or an equal-priority contender next in round-robin order, exists. In ARB_OWN, equal-priority contenders rotate every arbitration point.

Data-phase owner:
- hmaster_data <= hmaster on every hready=1 edge; held while hready=0.

arb_busy:
- arb_busy = (state == ARB_BURST).

Boundary cases:
- hready=0 freezes all state and outputs.
- A request dropped mid fixed burst does not end the burst.
- hprior changes take effect only at arbitration points.
- N_MASTER=1: hgrant is constant 1.

Optional Feature:
- Macro: AHB_ARB_LOCK_EN.
- Enabled: adds port hlock in N_MASTER. If the granted master has hlock=1 at an arbitration point, it keeps the grant regardless of other requests. The lock is released one arbitration point after hlock falls, which covers the final transfer.
- Disabled: no hlock port; locking is never honoured.

Decomposition:
- AHB_package: htrans_t and hburst_t enums, arb_state_t (ARB_IDLE/ARB_OWN/ARB_BURST), function burst_len(hburst_t) returning 0/4/8/16.
- Sub-module ahb_arb_pick: combinational highest-priority round-robin selector (inputs: req, prior, rr pointer; output: one-hot winner). Used once; separately unit-testable.

Test Plan:
- Reset, no requests, hready=1: hgrant=4'b0001, hmaster=0, hmaster_data=0 after release.
- Two masters at equal priority:
  - hbusreq=4'b0110, hprior all 0, SINGLE transfers -> grant alternates 2,1,2,1 on successive hready cycles.
  - Master 3 requests with hprior=1 while masters 1 and 2 request at 0 -> master 3 granted next cycle, holds while requesting.
- Fixed burst:
  - Master 1 INCR4 NONSEQ+3 SEQ with master 2 requesting at higher priority -> grant switches only after the 4th beat. arb_busy high for beats 1-3. Insert hready=0 on beat 2: grant and cnt frozen.
  - Master 1 WRAP8 terminated with IDLE after 3 beats -> re-arbitration on that cycle; master 2 granted next edge.
- hmaster_data lags hmaster by one accepted transfer; stays unchanged during 2 hready=0 wait states.
- Reset asserted mid-INCR16: outputs return to reset values without waiting for hclk. With AHB_ARB_LOCK_EN, a locked master 2 keeps the grant over a higher-priority request until one point after hlock=0.
